// File: rtl/bus_arb.sv
// Two-master round-robin arbiter for a single-outstanding request/acknowledge bus.
// Optional response timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb #(
   parameter int unsigned TIMEOUT = 32'd1048575
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0req,
   input  logic        m0wr,
   input  logic [31:0] m0addr,
   input  logic [31:0] m0wdata,
   input  logic [3:0]  m0wstrb,
   output logic        m0ack,
   output logic        m0err,
   output logic [31:0] m0rdata,
   input  logic        m1req,
   input  logic        m1wr,
   input  logic [31:0] m1addr,
   input  logic [31:0] m1wdata,
   input  logic [3:0]  m1wstrb,
   output logic        m1ack,
   output logic        m1err,
   output logic [31:0] m1rdata,
   output logic        outreq,
   output logic        outwr,
   output logic [31:0] outaddr,
   output logic [31:0] outwdata,
   output logic [3:0]  outwstrb,
   input  logic        outack,
   input  logic        outerr,
   input  logic [31:0] outrdata
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state, state_n;
   logic        pend0, pend0_n, pend1, pend1_n;
   logic        s0_wr, s0_wr_n, s1_wr, s1_wr_n;
   logic [31:0] s0_addr, s0_addr_n, s1_addr, s1_addr_n;
   logic [31:0] s0_wdata, s0_wdata_n, s1_wdata, s1_wdata_n;
   logic [3:0]  s0_wstrb, s0_wstrb_n, s1_wstrb, s1_wstrb_n;
   logic        last, last_n, cur, cur_n;
   logic        outreq_n, outwr_n;
   logic [31:0] outaddr_n, outwdata_n;
   logic [3:0]  outwstrb_n;
   logic        m0ack_n, m0err_n, m1ack_n, m1err_n;
   logic [31:0] m0rdata_n, m1rdata_n;
   logic        accept0, accept1, cand0, cand1, grant;
   logic        done, done_err;
   logic [31:0] done_data;
`ifdef BUS_ARB_TIMEOUT_EN
   logic [31:0] timer, timer_n;
`else
   logic        unused_timeout;
   assign unused_timeout = (TIMEOUT != 32'd0);
`endif

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pend0    <= 1'b0;
         pend1    <= 1'b0;
         s0_wr    <= 1'b0;
         s0_addr  <= 32'h0;
         s0_wdata <= 32'h0;
         s0_wstrb <= 4'h0;
         s1_wr    <= 1'b0;
         s1_addr  <= 32'h0;
         s1_wdata <= 32'h0;
         s1_wstrb <= 4'h0;
         last     <= 1'b1;
         cur      <= 1'b0;
         outreq   <= 1'b0;
         outwr    <= 1'b0;
         outaddr  <= 32'h0;
         outwdata <= 32'h0;
         outwstrb <= 4'h0;
         m0ack    <= 1'b0;
         m0err    <= 1'b0;
         m0rdata  <= 32'h0;
         m1ack    <= 1'b0;
         m1err    <= 1'b0;
         m1rdata  <= 32'h0;
`ifdef BUS_ARB_TIMEOUT_EN
         timer    <= 32'h0;
`endif
      end else begin
         state    <= state_n;
         pend0    <= pend0_n;
         pend1    <= pend1_n;
         s0_wr    <= s0_wr_n;
         s0_addr  <= s0_addr_n;
         s0_wdata <= s0_wdata_n;
         s0_wstrb <= s0_wstrb_n;
         s1_wr    <= s1_wr_n;
         s1_addr  <= s1_addr_n;
         s1_wdata <= s1_wdata_n;
         s1_wstrb <= s1_wstrb_n;
         last     <= last_n;
         cur      <= cur_n;
         outreq   <= outreq_n;
         outwr    <= outwr_n;
         outaddr  <= outaddr_n;
         outwdata <= outwdata_n;
         outwstrb <= outwstrb_n;
         m0ack    <= m0ack_n;
         m0err    <= m0err_n;
         m0rdata  <= m0rdata_n;
         m1ack    <= m1ack_n;
         m1err    <= m1err_n;
         m1rdata  <= m1rdata_n;
`ifdef BUS_ARB_TIMEOUT_EN
         timer    <= timer_n;
`endif
      end
   end

   // Slot capture, arbitration, completion and next-output computation.
   always_comb begin
      state_n    = state;
      pend0_n    = pend0;
      pend1_n    = pend1;
      s0_wr_n    = s0_wr;
      s0_addr_n  = s0_addr;
      s0_wdata_n = s0_wdata;
      s0_wstrb_n = s0_wstrb;
      s1_wr_n    = s1_wr;
      s1_addr_n  = s1_addr;
      s1_wdata_n = s1_wdata;
      s1_wstrb_n = s1_wstrb;
      last_n     = last;
      cur_n      = cur;
      outreq_n   = 1'b0;
      outwr_n    = outwr;
      outaddr_n  = outaddr;
      outwdata_n = outwdata;
      outwstrb_n = outwstrb;
      m0ack_n    = 1'b0;
      m0err_n    = m0err;
      m0rdata_n  = m0rdata;
      m1ack_n    = 1'b0;
      m1err_n    = m1err;
      m1rdata_n  = m1rdata;
      grant      = 1'b0;
      done       = 1'b0;
      done_err   = 1'b0;
      done_data  = 32'h0;
`ifdef BUS_ARB_TIMEOUT_EN
      timer_n    = timer;
`endif

      // A request is only taken when its slot is empty and the master is not in service.
      accept0 = m0req & ~pend0 & ~((state == BUSY) & (cur == 1'b0));
      accept1 = m1req & ~pend1 & ~((state == BUSY) & (cur == 1'b1));

      if (accept0) begin
         pend0_n    = 1'b1;
         s0_wr_n    = m0wr;
         s0_addr_n  = m0addr;
         s0_wdata_n = m0wdata;
         s0_wstrb_n = m0wstrb;
      end else begin
         pend0_n = pend0;
      end
      if (accept1) begin
         pend1_n    = 1'b1;
         s1_wr_n    = m1wr;
         s1_addr_n  = m1addr;
         s1_wdata_n = m1wdata;
         s1_wstrb_n = m1wstrb;
      end else begin
         pend1_n = pend1;
      end

      cand0 = pend0 | accept0;
      cand1 = pend1 | accept1;

      case (state)
         IDLE: begin
            if (cand0 | cand1) begin
               grant    = (cand0 & cand1) ? ~last : cand1;
               outreq_n = 1'b1;
               cur_n    = grant;
               state_n  = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
               timer_n  = 32'(TIMEOUT);
`endif
               if (grant) begin
                  pend1_n    = 1'b0;
                  outwr_n    = accept1 ? m1wr    : s1_wr;
                  outaddr_n  = accept1 ? m1addr  : s1_addr;
                  outwdata_n = accept1 ? m1wdata : s1_wdata;
                  outwstrb_n = accept1 ? m1wstrb : s1_wstrb;
               end else begin
                  pend0_n    = 1'b0;
                  outwr_n    = accept0 ? m0wr    : s0_wr;
                  outaddr_n  = accept0 ? m0addr  : s0_addr;
                  outwdata_n = accept0 ? m0wdata : s0_wdata;
                  outwstrb_n = accept0 ? m0wstrb : s0_wstrb;
               end
            end else begin
               state_n = IDLE;
            end
         end
         BUSY: begin
            if (outack) begin
               done      = 1'b1;
               done_err  = outerr;
               done_data = outrdata;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (timer == 32'h0) begin
               done      = 1'b1;
               done_err  = 1'b1;
               done_data = 32'h0;
            end else begin
               timer_n = timer - 32'd1;
`else
            end else begin
               done = 1'b0;
`endif
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (done) begin
         state_n = IDLE;
         last_n  = cur;
         if (cur) begin
            m1ack_n   = 1'b1;
            m1err_n   = done_err;
            m1rdata_n = done_data;
         end else begin
            m0ack_n   = 1'b1;
            m0err_n   = done_err;
            m0rdata_n = done_data;
         end
      end else begin
         last_n = last;
      end
   end

endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master arbiter for the single-transaction `out*` request/acknowledge bus driven by the AXI3 slave bridge. It sits between two requesters (port 0, normally the AXI3 bridge; port 1, an internal/debug master) and one downstream register/memory bus. It shares that bus round-robin, one transaction in flight at a time. Per-master requests are pulses, so the block captures them into pending slots and returns a one-cycle acknowledge with read data and error status.

## Interface
- `TIMEOUT`, 1048575: cycles to wait for `outack` before returning an error; 32-bit counter. Used only with `BUS_ARB_TIMEOUT_EN`.

Ports (X = 0, 1; identical per master):
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mXreq`  in  1  one-cycle request pulse; fields below valid in the same cycle.
- `mXwr`  in  1  1 = write, 0 = read.
- `mXaddr`  in  32  byte address.
- `mXwdata`  in  32  write data.
- `mXwstrb`  in  4  write byte strobes.
- `mXack`  out  1  one-cycle completion pulse.
- `mXerr`  out  1  error status, valid with `mXack`.
- `mXrdata`  out  32  read data, valid with `mXack`.
- `outreq`  out  1  one-cycle downstream request pulse.
- `outwr`, `outaddr[31:0]`, `outwdata[31:0]`, `outwstrb[3:0]`  out  downstream fields; held stable from `outreq` until completion.
- `outack`  in  1  downstream completion pulse.
- `outerr`  in  1  downstream error, valid with `outack`.
- `outrdata`  in  32  downstream read data, valid with `outack`.

## Operation
- Per-master slot: `pendX` plus latched wr/addr/wdata/wstrb.
  - `mXreq` while `pendX` = 0 and master X not in service: latch fields, set `pendX`.
  - `mXreq` while pending or in service is a protocol violation: ignored, slot unchanged.
- Candidates in IDLE: `pendX | mXreq`. Fields come from the inputs when `mXreq` is high this cycle, else from the slot.
- Round-robin: register `last` (reset 1).
  - Single candidate: grant it.
  - Both candidates: grant the one not equal to `last`.
- States:
  - IDLE: on a grant, register `outreq` = 1 and the granted fields, record `cur` = X, clear `pendX`, load timer = `TIMEOUT`, go to BUSY. The other master's same-cycle request is latched into its slot.
  - BUSY: `outreq` = 0. On `outack`:
    - `mXack` = 1, `mXrdata` = `outrdata`, `mXerr` = `outerr` for X = `cur`.
    - `last` = `cur`; go to IDLE.
  - Writes return `mXrdata` = `outrdata` unchanged; the master ignores it.
- `outack` in IDLE (spurious, or late after a timeout) is ignored.
- `mXack` and `outreq` are pulses; they are forced 0 every cycle they are not set.

## Timing
- Reset values:
  - Outputs: `outreq`, `outwr`, `outaddr`, `outwdata`, `outwstrb`, `m0ack`, `m1ack`, `m0err`, `m1err`, `m0rdata`, `m1rdata` all 0.
  - Internal: state IDLE, `pend0` = `pend1` = 0, `last` = 1.
- Reset mid-transaction abandons it; no `mXack` is issued; a later `outack` is ignored.
- Latency:
  - `mXreq` in cycle t with bus idle: `outreq` high in t+1.
  - `outack` in cycle u: `mXack` high in u+1, state IDLE in u+1.
  - Next grant: `outreq` no earlier than u+2.
- Both masters request in the same idle cycle: winner's `outreq` in t+1. Loser's `outreq` one cycle after the winner's `mXack`.
- A request arriving in the same cycle as `outack` is latched and served per round-robin at the next IDLE.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - In BUSY, the timer decrements each cycle.
  - If the timer is 0 and `outack` = 0: `mXack` = 1, `mXerr` = 1, `mXrdata` = 0, `last` = `cur`, go to IDLE.
  - `outack` in the same cycle the timer reaches 0 takes priority and is a normal completion.
- Undefined: no timer; BUSY waits indefinitely for `outack`; `TIMEOUT` unused.

## Test plan
- Single read: `m0req`, `m0addr` = 0x100, `m0wr` = 0 at t → `outreq` at t+1 with `outaddr` = 0x100, `outwr` = 0. Ack with `outrdata` = 0xDEADBEEF, `outerr` = 0 → `m0ack` one cycle later, `m0rdata` = 0xDEADBEEF, `m0err` = 0.
- Simultaneous requests from reset: m0 write 0x10/0x1234/strb 0xF, m1 read 0x20.
  - m0 is served first: `outwdata` = 0x1234, `outwstrb` = 0xF.
  - After m0's ack, m1's `outreq` follows with `outaddr` = 0x20.
  - Repeat both requests → m0 is served first again, since `last` = 1 after m1 was served.
- Back-to-back m1 requests with m0 requesting continuously → grants alternate m0, m1, m0, m1; neither port starves.
- Error passthrough: `outack` with `outerr` = 1 → `mXerr` = 1 on that master only.
- Timeout (macro defined, `TIMEOUT` = 8), no `outack` → `m1ack` = 1, `m1err` = 1, `m1rdata` = 0 nine cycles after `outreq`. A subsequent stray `outack` produces no ack.
- Reset in BUSY → all outputs 0 next cycle, no `mXack`. A following `outack` is ignored. A new `m0req` is served normally.
